// File: rtl/fp32_pkg.sv
// Shared constants and types for the FP32 multiplier datapath.
package fp32_pkg;

  localparam int          BIAS    = 127;
  localparam int          EXP_MAX = 255;
  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam int          FRAC_W  = 23;
  localparam int          MANT_W  = 24;
  localparam int          PROD_W  = 48;

  // Everything stage 1 hands to stage 2 apart from the exponent, whose
  // width is a parameter of the block and therefore lives beside this bundle.
  typedef struct packed {
    logic              sign;
    logic              is_nan;
    logic              is_inf;
    logic              is_zero;
    logic [FRAC_W-1:0] frac;
    logic              guard;
    logic              sticky;
  } stage1_t;

endpackage

// File: rtl/redondeo_rne.sv
// Round-to-nearest-even on a normalized 23-bit fraction, with the
// renormalizing exponent bump when the rounding carries out of the fraction.
module redondeo_rne #(
  parameter int EXP_W = 10
) (
  input  logic [fp32_pkg::FRAC_W-1:0] frac_in,
  input  logic                        guard,
  input  logic                        sticky,
  input  logic signed [EXP_W-1:0]     exp_in,
  output logic [fp32_pkg::FRAC_W-1:0] frac_out,
  output logic signed [EXP_W-1:0]     exp_out,
  output logic                        inexact
);
  import fp32_pkg::*;

  logic              round_up;
  logic [MANT_W-1:0] sum;

  // Ties go to the even fraction; a carry out of the fraction (all ones + 1)
  // leaves the fraction zero and moves the binary point up by one.
  assign round_up = guard & (sticky | frac_in[0]);
  assign sum      = {1'b0, frac_in} + {{FRAC_W{1'b0}}, round_up};
  assign frac_out = sum[FRAC_W-1:0];
  assign exp_out  = exp_in + $signed({{(EXP_W-1){1'b0}}, sum[MANT_W-1]});
  assign inexact  = guard | sticky;

endmodule

// File: rtl/normalizacion_redondeo.sv
// Final FP32 multiplier stage: normalize, round to nearest-even, range-check
// and pack. Two pipeline stages with valid/ready on both sides.
module normalizacion_redondeo #(
  parameter int EXP_W = 10,
  parameter int BIAS  = 127
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        Valido_in,
  output logic                        Listo_in,
  input  logic                        Signo,
  input  logic [EXP_W-1:0]            Exp_suma,
  input  logic [fp32_pkg::PROD_W-1:0] Producto,
  input  logic                        Es_nan,
  input  logic                        Es_inf,
  input  logic                        Es_cero,
  output logic                        Valido_out,
  input  logic                        Listo_out,
  output logic [31:0]                 Resultado,
  output logic                        Overflow,
  output logic                        Underflow,
  output logic                        Inexacto
);
  import fp32_pkg::*;

  // All-ones exponent; follows the bias if the block is built for another one.
  localparam logic signed [EXP_W-1:0] EXP_SAT  = EXP_W'(EXP_MAX + 2 * (BIAS - fp32_pkg::BIAS));
  localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] EXP_ZERO = EXP_W'(0);

  logic                    en1, en2, v1, v2;
  stage1_t                 s1_d, s1_q;
  logic signed [EXP_W-1:0] exp_d, exp_q;
  logic [FRAC_W-1:0]       rnd_frac;
  logic signed [EXP_W-1:0] rnd_exp;
  logic                    rnd_inexact;
  logic [31:0]             res_d;
  logic                    ovf_d, unf_d, inx_d;

  assign en2        = !v2 || Listo_out;
  assign en1        = !v1 || en2;
  assign Listo_in   = en1;
  assign Valido_out = v2;

  // Normalize: the product is either 1x.xxx or 01.xxx, so pick the fraction
  // window by the top bit and bump the exponent when it is set.
  always_comb begin
    s1_d         = '0;
    exp_d        = $signed(Exp_suma);
    s1_d.sign    = Signo;
    s1_d.is_nan  = Es_nan;
    s1_d.is_inf  = Es_inf;
    s1_d.is_zero = Es_cero;
    if (Producto[47]) begin
      s1_d.frac   = Producto[46:24];
      s1_d.guard  = Producto[23];
      s1_d.sticky = |Producto[22:0];
      exp_d       = $signed(Exp_suma) + EXP_ONE;
    end else begin
      s1_d.frac   = Producto[45:23];
      s1_d.guard  = Producto[22];
      s1_d.sticky = |Producto[21:0];
    end
  end

  // Stage-1 valid: cleared by reset, advances whenever stage 1 may load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
    end else if (en1) begin
      v1 <= Valido_in;
    end
  end

  // Stage-1 payload only moves on an accepted transfer.
  always_ff @(posedge clk) begin
    if (en1 && Valido_in) begin
      s1_q  <= s1_d;
      exp_q <= exp_d;
    end
  end

  redondeo_rne #(
    .EXP_W (EXP_W)
  ) u_redondeo_rne (
    .frac_in  (s1_q.frac),
    .guard    (s1_q.guard),
    .sticky   (s1_q.sticky),
    .exp_in   (exp_q),
    .frac_out (rnd_frac),
    .exp_out  (rnd_exp),
    .inexact  (rnd_inexact)
  );

  // Pack with special cases first, then range checks on the rounded exponent.
  always_comb begin
    res_d = 32'h0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = 1'b0;
    if (s1_q.is_nan) begin
      res_d = QNAN;
    end else if (s1_q.is_inf) begin
      res_d = {s1_q.sign, 8'hFF, 23'h0};
    end else if (s1_q.is_zero) begin
      res_d = {s1_q.sign, 31'h0};
    end else if (rnd_exp >= EXP_SAT) begin
      res_d = {s1_q.sign, 8'hFF, 23'h0};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if (rnd_exp <= EXP_ZERO) begin
      res_d = {s1_q.sign, 31'h0};
      unf_d = 1'b1;
      inx_d = 1'b1;
    end else begin
      res_d = {s1_q.sign, rnd_exp[7:0], rnd_frac};
      inx_d = rnd_inexact;
    end
  end

  // Output stage: holds its contents while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2        <= 1'b0;
      Resultado <= 32'h0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      Inexacto  <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        Resultado <= res_d;
        Overflow  <= ovf_d;
        Underflow <= unf_d;
        Inexacto  <= inx_d;
      end
    end
  end

endmodule

// File: tb/tb_normalizacion_redondeo.sv
// Self-checking bench for normalizacion_redondeo: directed table, backpressure
// and reset sequences, then randomized traffic against an arithmetic model.
module tb_normalizacion_redondeo;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
  } out_t;

  typedef struct {
    logic        sign;
    int          e;
    logic [47:0] prod;
    logic        nan;
    logic        inf;
    logic        zero;
    out_t        want;
  } vec_t;

  typedef struct {
    out_t want;
    int   tag;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n, Valido_in, Listo_in, Signo;
  logic [9:0]  Exp_suma;
  logic [47:0] Producto;
  logic        Es_nan, Es_inf, Es_cero;
  logic        Valido_out, Listo_out;
  logic [31:0] Resultado;
  logic        Overflow, Underflow, Inexacto;

  int   compared   = 0;
  int   mismatched = 0;
  sb_t  sb_q[$];
  out_t cur_want;
  int   cur_tag;
  bit   rand_ready = 1'b0;

  normalizacion_redondeo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Valido_in  (Valido_in),
    .Listo_in   (Listo_in),
    .Signo      (Signo),
    .Exp_suma   (Exp_suma),
    .Producto   (Producto),
    .Es_nan     (Es_nan),
    .Es_inf     (Es_inf),
    .Es_cero    (Es_cero),
    .Valido_out (Valido_out),
    .Listo_out  (Listo_out),
    .Resultado  (Resultado),
    .Overflow   (Overflow),
    .Underflow  (Underflow),
    .Inexacto   (Inexacto)
  );

  always #5 clk = ~clk;

  // Reference: treat the product as an integer, shift it down to a 24-bit
  // significand and round the discarded remainder against one half.
  function automatic out_t ref_model(logic sign, int e_in, logic [47:0] prod,
                                     logic nan, logic inf, logic zero);
    longint p, kept, rem, half;
    int     shift, e;
    out_t   r;
    r = '0;
    if (nan) begin
      r.res = 32'h7FC00000;
    end else if (inf) begin
      r.res = {sign, 8'hFF, 23'h0};
    end else if (zero) begin
      r.res = {sign, 31'h0};
    end else begin
      p     = longint'(prod);
      shift = (p >= (longint'(1) << 47)) ? 24 : 23;
      e     = e_in + shift - 23;
      kept  = p >> shift;
      rem   = p - (kept << shift);
      half  = longint'(1) << (shift - 1);
      if (rem > half || (rem == half && (kept % 2) == 1)) kept = kept + 1;
      if (kept == (longint'(1) << 24)) begin
        kept = kept / 2;
        e    = e + 1;
      end
      if (e >= 255)     r = {sign, 8'hFF, 23'h0, 3'b101};
      else if (e <= 0)  r = {sign, 31'h0, 3'b011};
      else begin
        r.res = {sign, 8'(e), 23'(kept)};
        r.inx = (rem != 0);
      end
    end
    return r;
  endfunction

  function automatic vec_t mk(logic sign, int e, logic [47:0] prod, logic nan,
                              logic inf, logic zero, logic [31:0] res,
                              logic ovf, logic unf, logic inx);
    vec_t v;
    v.sign = sign; v.e = e; v.prod = prod;
    v.nan = nan; v.inf = inf; v.zero = zero;
    v.want = {res, ovf, unf, inx};
    return v;
  endfunction

  task automatic checkOutput(input string what, input int tag,
                             input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s #%0d: got %h, want %h", what, tag, got, want);
    end
  endtask

  // Present one item from posedge+1 and hold it until the DUT takes it.
  task automatic applyStimulus(input logic sign, input int e, input logic [47:0] prod,
                               input logic nan, input logic inf, input logic zero,
                               input out_t want, input int tag);
    bit accepted;
    accepted  = 1'b0;
    Signo     = sign;
    Exp_suma  = 10'(e);
    Producto  = prod;
    Es_nan    = nan;
    Es_inf    = inf;
    Es_cero   = zero;
    cur_want  = want;
    cur_tag   = tag;
    Valido_in = 1'b1;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge clk);
      if (rst_n && Listo_in) accepted = 1'b1;
      @(posedge clk); #1;
    end
    Valido_in = 1'b0;
    if (!accepted) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept-timeout #%0d: Listo_in never rose, want 1", tag);
    end
  endtask

  task automatic sendVec(input vec_t v, input int tag);
    applyStimulus(v.sign, v.e, v.prod, v.nan, v.inf, v.zero, v.want, tag);
  endtask

  task automatic sendRandom(input int tag);
    logic [23:0] a, b;
    logic [47:0] p;
    int          e;
    logic        s, n, i, z;
    a = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
    b = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
    p = {24'b0, a} * {24'b0, b};
    if ($urandom_range(0, 3) == 0) begin
      p[21:0] = 22'b0;
      if (p[47]) p[22] = 1'b0;
    end
    if ($urandom_range(0, 3) == 0) e = int'($urandom_range(0, 635)) - 254;
    else                           e = int'($urandom_range(0, 262)) - 4;
    s = 1'($urandom_range(0, 1));
    n = ($urandom_range(0, 15) == 0);
    i = ($urandom_range(0, 15) == 0);
    z = ($urandom_range(0, 15) == 0);
    applyStimulus(s, e, p, n, i, z, ref_model(s, e, p, n, i, z), tag);
  endtask

  // Called right after an accept: output must stay low one cycle, then rise.
  task automatic checkLatency(input int tag);
    @(negedge clk);
    checkOutput("latency-early", tag, 64'(Valido_out), 64'(1'b0));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("latency-2cyc", tag, 64'(Valido_out), 64'(1'b1));
    @(posedge clk); #1;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || Valido_out) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: %0d results outstanding, want 0", sb_q.size());
    end
  endtask

  // Scoreboard monitor: samples mid-cycle what the next edge will transfer.
  initial begin : monitor
    bit   stall_prev;
    out_t stall_val;
    out_t got;
    sb_t  s;
    stall_prev = 1'b0;
    stall_val  = '0;
    forever begin
      @(negedge clk);
      got = {Resultado, Overflow, Underflow, Inexacto};
      if (rst_n !== 1'b1) begin
        sb_q.delete();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev)
          checkOutput("stall-hold", -1, 64'({Valido_out, got}), 64'({1'b1, stall_val}));
        if (Valido_in && Listo_in) sb_q.push_back('{cur_want, cur_tag});
        if (Valido_out && Listo_out) begin
          if (sb_q.size() == 0) begin
            checkOutput("unexpected-output", -1, 64'(got), 64'(0));
          end else begin
            s = sb_q.pop_front();
            checkOutput("result", s.tag, 64'(got), 64'(s.want));
          end
        end
        stall_prev = Valido_out && !Listo_out;
        stall_val  = got;
      end
    end
  end

  // Downstream readiness during the random phase.
  initial begin : ready_gen
    forever begin
      @(posedge clk); #1;
      if (rand_ready) Listo_out = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : main
    vec_t vt[$];
    rst_n = 1'b0; Valido_in = 1'b0; Listo_out = 1'b0;
    Signo = 1'b0; Exp_suma = '0; Producto = '0;
    Es_nan = 1'b0; Es_inf = 1'b0; Es_cero = 1'b0;

    vt.push_back(mk(0, 127,  48'h900000000000, 0, 0, 0, 32'h40100000, 0, 0, 0));
    vt.push_back(mk(0, 127,  48'h400000400000, 0, 0, 0, 32'h3F800000, 0, 0, 1));
    vt.push_back(mk(0, 127,  48'h400000C00000, 0, 0, 0, 32'h3F800002, 0, 0, 1));
    vt.push_back(mk(0, 127,  48'h7FFFFFC00000, 0, 0, 0, 32'h40000000, 0, 0, 1));
    vt.push_back(mk(1, 254,  48'h800000000000, 0, 0, 0, 32'hFF800000, 1, 0, 1));
    vt.push_back(mk(0, 0,    48'h400000000000, 0, 0, 0, 32'h00000000, 0, 1, 1));
    vt.push_back(mk(0, 127,  48'h900000000000, 1, 0, 0, 32'h7FC00000, 0, 0, 0));
    vt.push_back(mk(1, 127,  48'h900000000000, 0, 1, 0, 32'hFF800000, 0, 0, 0));
    vt.push_back(mk(1, 127,  48'h900000000000, 0, 0, 1, 32'h80000000, 0, 0, 0));
    vt.push_back(mk(0, 254,  48'h400000000000, 0, 0, 0, 32'h7F000000, 0, 0, 0));
    vt.push_back(mk(0, 1,    48'h400000000000, 0, 0, 0, 32'h00800000, 0, 0, 0));
    vt.push_back(mk(0, 254,  48'h7FFFFFC00000, 0, 0, 0, 32'h7F800000, 1, 0, 1));
    vt.push_back(mk(1, -254, 48'h900000000000, 0, 0, 0, 32'h80000000, 0, 1, 1));
    vt.push_back(mk(0, 381,  48'hC00000000000, 0, 0, 0, 32'h7F800000, 1, 0, 1));
    vt.push_back(mk(1, 127,  48'h900000000000, 1, 1, 1, 32'h7FC00000, 0, 0, 0));
    vt.push_back(mk(0, 127,  48'h900000000000, 0, 1, 1, 32'h7F800000, 0, 0, 0));
    vt.push_back(mk(0, 127,  48'h400000400001, 0, 0, 0, 32'h3F800001, 0, 0, 1));
    vt.push_back(mk(0, -1,   48'h800000000000, 0, 0, 0, 32'h00000000, 0, 1, 1));
    vt.push_back(mk(0, 0,    48'h800000000000, 0, 0, 0, 32'h00800000, 0, 0, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset-valid", 0, 64'(Valido_out), 64'(1'b0));
    checkOutput("reset-outputs", 0, 64'({Resultado, Overflow, Underflow, Inexacto}), 64'(0));
    checkOutput("reset-ready", 0, 64'(Listo_in), 64'(1'b1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    Listo_out = 1'b1;

    sendVec(vt[0], 0);
    checkLatency(0);
    for (int i = 1; i < vt.size(); i++) sendVec(vt[i], i);
    waitDrain();

    $display("[TB] backpressure sequence");
    Listo_out = 1'b0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        Listo_out = 1'b1;
      end
      begin
        sendRandom(100);
        sendRandom(101);
        #1;
        checkOutput("bp-ready-low", 101, 64'(Listo_in), 64'(1'b0));
        sendRandom(102);
        sendRandom(103);
      end
    join
    waitDrain();

    $display("[TB] reset mid-stream");
    Listo_out = 1'b0;
    sendRandom(200);
    sendRandom(201);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst-mid-valid", 201, 64'(Valido_out), 64'(1'b0));
    checkOutput("rst-mid-result", 201, 64'(Resultado), 64'(0));
    @(posedge clk); #1;
    Listo_out = 1'b1;
    sendRandom(202);
    checkLatency(202);
    waitDrain();

    $display("[TB] random traffic");
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
      sendRandom(1000 + i);
    end
    rand_ready = 1'b0;
    Listo_out  = 1'b1;
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/normalizacion_redondeo.md
Name: normalizacion_redondeo

Overview:
- Final stage of the FP32 multiplier datapath. Consumes the product sign from the sign XOR, the biased exponent sum, the 48-bit significand product and special-case flags from the upstream classifier.
- Normalizes, rounds to nearest-even, range-checks and packs the IEEE-754 single-precision result.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- EXP_W, 10, width of the signed two's-complement exponent path.
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- Valido_in  in  1  upstream data valid
- Listo_in  out  1  this block can accept data
- Signo  in  1  product sign (Signo_A ^ Signo_B)
- Exp_suma  in  10  Ea+Eb-BIAS, signed two's complement
- Producto  in  48  24x24 significand product, hidden bits included
- Es_nan  in  1  result must be NaN (includes inf×0)
- Es_inf  in  1  result must be infinity
- Es_cero  in  1  result must be zero
- Valido_out  out  1  Resultado valid
- Listo_out  in  1  downstream can accept
- Resultado  out  32  packed FP32 result
- Overflow  out  1  exponent overflow
- Underflow  out  1  exponent underflow (flush to zero)
- Inexacto  out  1  result was rounded (guard|sticky nonzero)

Behaviour:
- Reset: clk and rst_n are the single clock and reset. Reset is synchronous and active-low.
  - On a clk edge with rst_n=0, both stage valids clear.
  - Valido_out=0; Resultado=32'h0; Overflow=Underflow=Inexacto=0.
  - Reset mid-operation discards in-flight data. No output is produced for it.
- Handshake:
  - en2 = !v2 | Listo_out; en1 = !v1 | en2; Listo_in = en1 (combinational).
  - A transfer occurs on Valido_in & Listo_in. Output is consumed on Valido_out & Listo_out.
  - While stalled, Resultado and flags hold stable and Valido_out stays high.
- Latency: 2 cycles from accepted input to Valido_out when never stalled. Throughput is 1 per cycle.
- Stage 1 (normalize):
  - If Producto[47]=1: frac=Producto[46:24], G=Producto[23], S=|Producto[22:0], e=Exp_suma+1.
  - Else: frac=Producto[45:23], G=Producto[22], S=|Producto[21:0], e=Exp_suma.
  - Register sign, the special flags, frac, G, S and e.
- Stage 2 (round/pack):
  - Round up when G & (S | frac[0]).
  - If the rounded frac carries out (all ones +1): frac=0, e=e+1.
  - Inexacto = G|S, for non-special results only.
- Priority:
  1. Es_nan: 32'h7FC00000, all flags 0.
  2. Es_inf: {sign, 8'hFF, 23'h0}.
  3. Es_cero: {sign, 31'h0}.
  4. Final e >= 255 (signed): {sign, 8'hFF, 23'h0}, Overflow=1, Inexacto=1.
  5. Final e <= 0 (signed): {sign, 31'h0}, Underflow=1, Inexacto=1. Subnormals are not produced.
  6. Otherwise: {sign, e[7:0], frac}.
- The exponent path is EXP_W bits signed throughout. No wrap-around is permitted. Upstream guarantees -254 <= Exp_suma <= 381.
- Simultaneous input accept and output consume in the same cycle is legal and must not drop or duplicate data.

Decomposition:
- Shared package fp32_pkg:
  - Constants: BIAS, EXP_MAX=255, QNAN=32'h7FC00000, FRAC_W=23, MANT_W=24, PROD_W=48.
  - Typedef for the stage-1 register bundle.
- One natural sub-module: redondeo_rne, the combinational round-to-nearest-even plus carry/renormalize logic used in stage 2.

Test Plan:
- 1.5×1.5: Signo=0, Exp_suma=127, Producto=48'h900000000000 → Resultado=32'h40100000 after 2 cycles, all flags 0.
- Tie-to-even: Exp_suma=127, Producto=48'h400000400000 → 32'h3F800000, Inexacto=1. Producto=48'h400000C00000 → 32'h3F800002, Inexacto=1.
- Rounding carry: Producto=48'h7FFFFFC00000, Exp_suma=127 → 32'h40000000, Inexacto=1.
- Overflow: Exp_suma=254, Producto=48'h800000000000, Signo=1 → 32'hFF800000, Overflow=1.
- Underflow: Exp_suma=0, Producto=48'h400000000000 → 32'h00000000, Underflow=1.
- Specials: Es_nan=1 → 32'h7FC00000; Es_inf=1 with Signo=1 → 32'hFF800000; Es_cero=1 with Signo=1 → 32'h80000000.
- Backpressure: stream 4 inputs with Listo_out low for 3 cycles.
  - Listo_in drops after 2 accepted inputs.
  - Resultado holds stable while stalled.
  - All 4 results emerge in order, none lost.
- Reset mid-stream: pulse rst_n=0 one cycle with 2 items in flight → Valido_out=0 next cycle, then the next accepted input appears 2 cycles later.
